lcm_reg_pkt_rd: RTL and testbench
=================================

LCM_REG_PKT_RD -- requirements
Module: lcm_reg_pkt_rd

Interface
REQ-001 SHALL have parameter NREG, default 16, number of 64-bit readable registers, range 2..255.
REQ-002 SHALL have parameter SEQ_W, default 16, packet sequence counter width, range 8..16.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port reg_bus  input  NREG*64  flat register vector; register i is in bits [64*i+63:64*i].
REQ-007 SHALL have port rd_req  input  1  read request pulse.
REQ-008 SHALL have port rd_start  input  8  first register index.
REQ-009 SHALL have port rd_cnt  input  8  number of registers to read.
REQ-010 SHALL have port rd_busy  output  1  high from request accept until the packet completes.
REQ-011 SHALL have port out_lcm_data_ready  input  1  downstream can take one beat.
REQ-012 SHALL have port out_lcm_data  output  134  beat: [133:132] flag, [131:128] invalid-byte count, [127:0] payload.
REQ-013 SHALL have port out_lcm_data_wr  output  1  beat write strobe.
REQ-014 SHALL have port out_lcm_data_valid  output  1  packet good (1) or discard (0).
REQ-015 SHALL have port out_lcm_data_valid_wr  output  1  strobe for out_lcm_data_valid.

Function
REQ-016 SHALL use the FSM states IDLE, HEAD, DATA and DONE.
REQ-017 SHALL accept rd_req only in IDLE; a request arriving while rd_busy=1 SHALL be dropped silently.
REQ-018 On accept, SHALL latch start and effective count, then go to HEAD with rd_busy=1 in the following cycle.
REQ-019 SHALL set effective count to min(rd_cnt, NREG-rd_start).
REQ-020 SHALL treat rd_cnt=0 or rd_start>=NREG as an error request; effective count is 0.
REQ-021 SHALL emit a beat (out_lcm_data_wr=1 the next cycle) only from a cycle in HEAD or DATA with out_lcm_data_ready=1; otherwise out_lcm_data_wr=0 and the state holds.
REQ-022 Header beat SHALL carry flag 2'b01, invalid count 0, [127:120] start, [119:112] effective count, [111:96] sequence number zero-extended, [95:0] zero.
REQ-023 Each data beat SHALL carry two consecutive registers: lower index in [127:64], next index in [63:0].
REQ-024 Data beats SHALL use flag 2'b11, except the final data beat, which SHALL use 2'b10.
REQ-025 If the effective count is odd, the final data beat SHALL have [63:0]=0 and invalid count 8; otherwise invalid count SHALL be 0.
REQ-026 For an error request, the header SHALL be the only beat and SHALL carry flag 2'b10.
REQ-027 One cycle after the last beat strobe, in DONE, SHALL pulse out_lcm_data_valid_wr for one cycle, with out_lcm_data_valid = 1 for a good request and 0 for an error request; then return to IDLE with rd_busy=0.
REQ-028 SHALL increment the sequence number by 1 per completed packet, error packets included, wrapping modulo 2^SEQ_W.
REQ-029 Total packet length SHALL be 1 + ceil(count/2) beats; back-pressure SHALL never drop, repeat or reorder beats.

Reset
REQ-030 While rst_n=0 at a rising edge, SHALL force state IDLE, sequence 0, and all outputs 0 (out_lcm_data = 134'b0).
REQ-031 A reset mid-packet SHALL abort the packet with no further beats and no valid_wr strobe.

Configuration
REQ-032 With macro LCM_REG_RD_SNAPSHOT_EN defined, SHALL copy all of reg_bus into a snapshot bank on request accept, so every beat of the packet reflects that single cycle.
REQ-033 Without LCM_REG_RD_SNAPSHOT_EN, SHALL read reg_bus live in the cycle each data beat is launched, and SHALL instantiate no snapshot storage.

Structure
REQ-034 Package lcm_pkg SHALL hold the constants LCM_DATA_W=134, REG_W=64, FLAG_HEAD=2'b01, FLAG_MID=2'b11, FLAG_TAIL=2'b10, and the FSM state typedef.
REQ-035 Snapshot storage SHALL be a sub-module lcm_reg_snap, instantiated only under LCM_REG_RD_SNAPSHOT_EN.

Verification
REQ-036 NREG=16, reg i=i+1, ready=1, start=0, cnt=4 -> beats: head(01, start 0, count 4, seq 0); (11, 1|2); (10, 3|4); then valid_wr with valid=1.
REQ-037 start=3, cnt=3 -> head count 3; (11, 4|5); (10, 6|0, invalid count 8); valid=1.
REQ-038 start=14, cnt=5 -> count clamped to 2; single data beat (10, 15|16).
REQ-039 start=20 -> one header beat with flag 10 and count 0; valid_wr with valid=0; sequence still increments.
REQ-040 ready toggling 1/0 every cycle during cnt=8 -> exactly 5 beats, in order; second rd_req while busy -> ignored.
REQ-041 Snapshot build: change reg_bus after accept -> packet carries accept-time values; live build: packet carries changed values; rst_n=0 mid-packet -> outputs 0 and no valid_wr.

Source files
------------

// File: rtl/lcm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcm_pkg                                                      |
// | Description : Shared constants, FSM state type and the effective-count     |
// |               helper for the LCM register packet reader.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lcm_pkg;

  localparam int LCM_DATA_W = 134;
  localparam int REG_W      = 64;

  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_MID  = 2'b11;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } lcm_state_e;

  // Number of registers actually returned: min(cnt, nreg-start), or 0 when
  // the request is malformed (zero count or start beyond the register file).
  function automatic logic [7:0] eff_count(input logic [7:0] start,
                                           input logic [7:0] cnt,
                                           input logic [8:0] nreg);
    logic [8:0] avail;
    avail = 9'd0;
    if (cnt == 8'd0 || {1'b0, start} >= nreg) begin
      return 8'd0;
    end
    avail = nreg - {1'b0, start};
    if ({1'b0, cnt} < avail) begin
      return cnt;
    end
    return avail[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcm_reg_snap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcm_reg_snap                                                 |
// | Description : Snapshot bank holding a full copy of the register vector,   |
// |               captured in the cycle a read request is accepted.           |
// | Ports       : clk    - rising-edge clock                                   |
// |               rst_n  - synchronous active-low reset                        |
// |               cap_i  - capture strobe                                      |
// |               bus_i  - live register vector                                |
// |               snap_o - captured register vector                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcm_reg_snap
  import lcm_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_i,
  input  logic [NREG*REG_W-1:0] bus_i,
  output logic [NREG*REG_W-1:0] snap_o
);

  logic [NREG*REG_W-1:0] snap_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (cap_i) begin
      snap_q <= bus_i;
    end
  end

  assign snap_o = snap_q;

endmodule
`default_nettype wire

// File: rtl/lcm_reg_pkt_rd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcm_reg_pkt_rd                                               |
// | Description : Reads a run of 64-bit registers and returns them as an LCM  |
// |               packet: one header beat, then two registers per data beat,  |
// |               followed by a packet-status strobe.                         |
// | Ports       : clk, rst_n            - clock, synchronous active-low reset  |
// |               reg_bus               - NREG x 64-bit flat register vector   |
// |               rd_req/start/cnt      - read request, first index, count     |
// |               rd_busy               - packet in progress                   |
// |               out_lcm_data_ready    - downstream can accept a beat         |
// |               out_lcm_data/_wr      - beat and its write strobe            |
// |               out_lcm_data_valid/_wr- packet good/discard and its strobe   |
// | Options     : LCM_REG_RD_SNAPSHOT_EN - when defined, registers are copied  |
// |               into a snapshot bank at request accept; otherwise reg_bus   |
// |               is read live as each data beat is launched.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcm_reg_pkt_rd
  import lcm_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int SEQ_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREG*REG_W-1:0] reg_bus,
  input  logic                  rd_req,
  input  logic [7:0]            rd_start,
  input  logic [7:0]            rd_cnt,
  output logic                  rd_busy,
  input  logic                  out_lcm_data_ready,
  output logic [LCM_DATA_W-1:0] out_lcm_data,
  output logic                  out_lcm_data_wr,
  output logic                  out_lcm_data_valid,
  output logic                  out_lcm_data_valid_wr
);

  localparam logic [8:0] C_NREG9 = 9'(NREG);

  lcm_state_e            state_q;
  logic [7:0]            start_q;
  logic [7:0]            cnt_q;
  logic                  err_q;
  logic [7:0]            idx_q;
  logic [7:0]            rem_q;
  logic [SEQ_W-1:0]      seq_q;

  logic [NREG*REG_W-1:0] src_bus;
  logic [REG_W-1:0]      w_regs [256];

  logic [15:0]           seq16_d;
  logic [7:0]            eff_cnt_d;
  logic                  last_d;
  logic                  odd_d;
  logic [REG_W-1:0]      hi_d;
  logic [LCM_DATA_W-1:0] head_beat_d;
  logic [LCM_DATA_W-1:0] data_beat_d;

`ifdef LCM_REG_RD_SNAPSHOT_EN
  logic accept_d;
  assign accept_d = (state_q == IDLE) && rd_req;

  lcm_reg_snap #(
    .NREG (NREG)
  ) u_snap (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap_i  (accept_d),
    .bus_i  (reg_bus),
    .snap_o (src_bus)
  );
`else
  assign src_bus = reg_bus;
`endif

  // Register view padded to 256 entries so any 8-bit index is in range;
  // indices past the register file read as zero.
  for (genvar i = 0; i < 256; i++) begin : g_reg
    if (i < NREG) begin : g_present
      assign w_regs[i] = src_bus[REG_W*i +: REG_W];
    end else begin : g_absent
      assign w_regs[i] = '0;
    end
  end

  always_comb begin
    seq16_d     = 16'(seq_q);
    eff_cnt_d   = eff_count(rd_start, rd_cnt, C_NREG9);
    last_d      = (rem_q <= 8'd2);
    // A single remaining register means the tail beat is half empty.
    odd_d       = (rem_q == 8'd1);
    hi_d        = odd_d ? '0 : w_regs[idx_q + 8'd1];
    head_beat_d = {(err_q ? FLAG_TAIL : FLAG_HEAD), 4'd0, start_q, cnt_q,
                   seq16_d, 96'd0};
    data_beat_d = {(last_d ? FLAG_TAIL : FLAG_MID), (odd_d ? 4'd8 : 4'd0),
                   w_regs[idx_q], hi_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q               <= IDLE;
      start_q               <= '0;
      cnt_q                 <= '0;
      err_q                 <= 1'b0;
      idx_q                 <= '0;
      rem_q                 <= '0;
      seq_q                 <= '0;
      rd_busy               <= 1'b0;
      out_lcm_data          <= '0;
      out_lcm_data_wr       <= 1'b0;
      out_lcm_data_valid    <= 1'b0;
      out_lcm_data_valid_wr <= 1'b0;
    end else begin
      out_lcm_data_wr       <= 1'b0;
      out_lcm_data_valid_wr <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            start_q <= rd_start;
            cnt_q   <= eff_cnt_d;
            err_q   <= (eff_cnt_d == 8'd0);
            idx_q   <= rd_start;
            rem_q   <= eff_cnt_d;
            rd_busy <= 1'b1;
            state_q <= HEAD;
          end
        end
        HEAD: begin
          if (out_lcm_data_ready) begin
            out_lcm_data    <= head_beat_d;
            out_lcm_data_wr <= 1'b1;
            state_q         <= err_q ? DONE : DATA;
          end
        end
        DATA: begin
          if (out_lcm_data_ready) begin
            out_lcm_data    <= data_beat_d;
            out_lcm_data_wr <= 1'b1;
            idx_q           <= idx_q + 8'd2;
            if (last_d) begin
              rem_q   <= 8'd0;
              state_q <= DONE;
            end else begin
              rem_q   <= rem_q - 8'd2;
            end
          end
        end
        DONE: begin
          // Reached the cycle the last beat strobe is on the output.
          out_lcm_data_valid    <= ~err_q;
          out_lcm_data_valid_wr <= 1'b1;
          seq_q                 <= seq_q + SEQ_W'(1);
          rd_busy               <= 1'b0;
          state_q               <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcm_reg_pkt_rd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lcm_reg_pkt_rd                                            |
// | Description : Scoreboard bench for lcm_reg_pkt_rd (NREG=16, SEQ_W=16).     |
// |               Expected beats and packet status are queued when a request  |
// |               is issued and compared as the DUT emits them.               |
// | Options     : LCM_REG_RD_SNAPSHOT_EN selects the snapshot expectation.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lcm_reg_pkt_rd;

  localparam int NREG = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREG*64-1:0] reg_bus;
  logic              rd_req;
  logic [7:0]        rd_start;
  logic [7:0]        rd_cnt;
  logic              rd_busy;
  logic              out_lcm_data_ready;
  logic [133:0]      out_lcm_data;
  logic              out_lcm_data_wr;
  logic              out_lcm_data_valid;
  logic              out_lcm_data_valid_wr;

  logic [63:0]       regs [NREG];
  logic [133:0]      beat_q  [$];
  logic              valid_q [$];
  logic [15:0]       seq_m;
  int                n_checks = 0;
  int                n_errors = 0;
  int                beats_seen = 0;

  lcm_reg_pkt_rd #(.NREG(NREG), .SEQ_W(16)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .reg_bus               (reg_bus),
    .rd_req                (rd_req),
    .rd_start              (rd_start),
    .rd_cnt                (rd_cnt),
    .rd_busy               (rd_busy),
    .out_lcm_data_ready    (out_lcm_data_ready),
    .out_lcm_data          (out_lcm_data),
    .out_lcm_data_wr       (out_lcm_data_wr),
    .out_lcm_data_valid    (out_lcm_data_valid),
    .out_lcm_data_valid_wr (out_lcm_data_valid_wr)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREG; i++) reg_bus[64*i +: 64] = regs[i];
  end

  task automatic check_eq(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected packet for a request, built from the register values now held.
  task automatic push_pkt(input logic [7:0] s, input logic [7:0] c);
    int eff;
    logic err;
    logic [63:0] lo, hi;
    err = (c == 8'd0) || (int'(s) >= NREG);
    eff = err ? 0 : ((int'(c) < NREG - int'(s)) ? int'(c) : NREG - int'(s));
    beat_q.push_back({(err ? 2'b10 : 2'b01), 4'd0, s, 8'(eff), seq_m, 96'd0});
    for (int k = 0; k < eff; k += 2) begin
      lo = regs[int'(s) + k];
      hi = (k + 1 < eff) ? regs[int'(s) + k + 1] : 64'd0;
      beat_q.push_back({((k + 2 >= eff) ? 2'b10 : 2'b11),
                        ((k + 1 < eff) ? 4'd0 : 4'd8), lo, hi});
    end
    valid_q.push_back(!err);
    seq_m = seq_m + 16'd1;
  endtask

  task automatic issue(input logic [7:0] s, input logic [7:0] c);
    rd_req = 1'b1; rd_start = s; rd_cnt = c;
    @(posedge clk); #1;
    rd_req = 1'b0;
    check_eq("busy_after_accept", 134'(rd_busy), 134'(1));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((beat_q.size() != 0 || valid_q.size() != 0 || rd_busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_done"}, 134'(n >= 300), 134'(0));
    check_eq({tag, "_idle"}, 134'(rd_busy), 134'(0));
  endtask

  always @(negedge clk) begin
    if (out_lcm_data_wr) begin
      beats_seen++;
      if (beat_q.size() == 0) check_eq("extra_beat", out_lcm_data, 134'd0 - 134'd1);
      else check_eq("beat", out_lcm_data, beat_q.pop_front());
    end
    if (out_lcm_data_valid_wr) begin
      if (valid_q.size() == 0) check_eq("extra_valid_wr", 134'(1), 134'(0));
      else check_eq("valid", 134'(out_lcm_data_valid), 134'(valid_q.pop_front()));
    end
  end

  task automatic restore_regs();
    for (int i = 0; i < NREG; i++) regs[i] = 64'(i + 1);
  endtask

  initial begin
    int n, base;
    restore_regs();
    rst_n = 1'b0; rd_req = 1'b0; rd_start = '0; rd_cnt = '0;
    out_lcm_data_ready = 1'b0; seq_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", out_lcm_data, 134'd0);
    check_eq("rst_flags", {130'd0, rd_busy, out_lcm_data_wr, out_lcm_data_valid,
             out_lcm_data_valid_wr}, 134'd0);
    rst_n = 1'b1;
    out_lcm_data_ready = 1'b1;
    @(posedge clk); #1;

    // Basic, odd-tail, clamped and error requests.
    push_pkt(8'd0, 8'd4);  issue(8'd0, 8'd4);  wait_done("even4");
    push_pkt(8'd3, 8'd3);  issue(8'd3, 8'd3);  wait_done("odd3");
    push_pkt(8'd14, 8'd5); issue(8'd14, 8'd5); wait_done("clamp");
    push_pkt(8'd20, 8'd2); issue(8'd20, 8'd2); wait_done("err_start");
    push_pkt(8'd5, 8'd0);  issue(8'd5, 8'd0);  wait_done("err_cnt0");
    push_pkt(8'd15, 8'd1); issue(8'd15, 8'd1); wait_done("last_reg");

    // Back-pressure toggling every cycle plus a request while busy.
    base = beats_seen;
    push_pkt(8'd2, 8'd8); issue(8'd2, 8'd8);
    n = 0;
    while ((beat_q.size() != 0 || valid_q.size() != 0 || rd_busy) && n < 300) begin
      out_lcm_data_ready = ~out_lcm_data_ready;
      rd_req = (n == 2); rd_start = 8'd1; rd_cnt = 8'd2;
      @(posedge clk); #1;
      n++;
    end
    rd_req = 1'b0;
    out_lcm_data_ready = 1'b1;
    check_eq("bp_done", 134'(n >= 300), 134'(0));
    check_eq("bp_beats", 134'(beats_seen - base), 134'(5));
    repeat (4) @(posedge clk);
    #1;

    // Register changes after accept: snapshot keeps old values, live sees new.
    out_lcm_data_ready = 1'b0;
`ifdef LCM_REG_RD_SNAPSHOT_EN
    push_pkt(8'd0, 8'd4);
`endif
    issue(8'd0, 8'd4);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NREG; i++) regs[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
`ifndef LCM_REG_RD_SNAPSHOT_EN
    push_pkt(8'd0, 8'd4);
`endif
    out_lcm_data_ready = 1'b1;
    wait_done("snap");
    restore_regs();

    // Reset in the middle of a packet: remaining beats and status vanish.
    base = beats_seen;
    push_pkt(8'd0, 8'd8); issue(8'd0, 8'd8);
    n = 0;
    while (beats_seen - base < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("mid_rst_reach", 134'(n >= 100), 134'(0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    beat_q.delete(); valid_q.delete(); seq_m = '0;
    check_eq("mid_rst_data", out_lcm_data, 134'd0);
    check_eq("mid_rst_flags", {130'd0, rd_busy, out_lcm_data_wr, out_lcm_data_valid,
             out_lcm_data_valid_wr}, 134'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = beats_seen;
    repeat (10) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", 134'(beats_seen - base), 134'(0));

    // Sequence restarts from zero after reset.
    push_pkt(8'd6, 8'd2); issue(8'd6, 8'd2); wait_done("post_rst");

    check_eq("sb_drain", 134'(beat_q.size() + valid_q.size()), 134'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
